pc_run_ctrl: RTL and testbench

Parametrised run-control block for the MIPS core PC. It gates PC advance (run_o) with these modes: free-run to an end address, single-step, and run-N-instructions. It adds NUM_BP address breakpoints, a halt-cause register and a retired-instruction counter. It sits between the board/UART debug controls and the core's pc_run_en input, and supersedes the ad-hoc run-hold flop.

---
 rtl/pc_run_pkg.sv | 35 +++
 rtl/pc_run_ctrl_if.sv | 54 +++++
 rtl/pc_bp_match.sv | 40 ++++
 rtl/pc_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_run_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_run_pkg.sv
// -----------------------------------------------------------------------------
// pc_run_pkg
// Shared encodings for the PC run controller: run modes, halt causes and the
// controller state enum. Imported by pc_run_ctrl_if, pc_bp_match and
// pc_run_ctrl.
// -----------------------------------------------------------------------------
package pc_run_pkg;

    // Run modes as presented on mode_i. Encoding 3 is reserved and behaves
    // as FREE; norm_mode() folds it so the rest of the design sees 3 modes.
    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;

    // Halt causes reported on halt_cause_o.
    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_END   = 3'd1;
    localparam logic [2:0] CAUSE_BREAK = 3'd2;
    localparam logic [2:0] CAUSE_COUNT = 3'd3;
    localparam logic [2:0] CAUSE_STEP  = 3'd4;
    localparam logic [2:0] CAUSE_STOP  = 3'd5;

    // Controller state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } run_state_t;

    // Map the reserved mode encoding onto FREE.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_FREE : m;
    endfunction

endpackage

// File: rtl/pc_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_run_ctrl_if
// Bundles the debug-control inputs and run-control outputs of pc_run_ctrl.
//   master : debug controller side (drives start/stop/clr, mode, addresses,
//            breakpoints and the core PC; observes run/clear/status)
//   slave  : pc_run_ctrl itself
//
// Signalling: start_i and clr_i are single-cycle pulses sampled on the rising
// clock edge; start_i is only accepted when busy_o is low, clr_i is accepted
// in every state and wins over start_i/stop_i in the same cycle. stop_i is a
// level (a pulse works too) that only matters while busy_o is high. run_o is
// combinational and is the per-cycle PC advance enable; pc_clr_o is a
// registered one-cycle pulse following clr_i. There is no backpressure.
// -----------------------------------------------------------------------------
interface pc_run_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 32
) ();
    import pc_run_pkg::*;

    logic                     start_i;
    logic                     stop_i;
    logic                     clr_i;
    logic [1:0]               mode_i;
    logic [CNT_W-1:0]         step_cnt_i;
    logic [PC_W-3:0]          end_addr_i;
    logic [PC_W-1:0]          pc_i;
    logic [NUM_BP-1:0]        bp_en_i;
    logic [NUM_BP*PC_W-1:0]   bp_addr_i;

    logic                     run_o;
    logic                     pc_clr_o;
    logic                     busy_o;
    logic [2:0]               halt_cause_o;
    logic [2:0]               bp_idx_o;
    logic [CNT_W-1:0]         retired_o;
    run_state_t               state_o;     // controller state, for debug

    modport master (
        output start_i, stop_i, clr_i, mode_i, step_cnt_i, end_addr_i,
               pc_i, bp_en_i, bp_addr_i,
        input  run_o, pc_clr_o, busy_o, halt_cause_o, bp_idx_o, retired_o,
               state_o
    );

    modport slave (
        input  start_i, stop_i, clr_i, mode_i, step_cnt_i, end_addr_i,
               pc_i, bp_en_i, bp_addr_i,
        output run_o, pc_clr_o, busy_o, halt_cause_o, bp_idx_o, retired_o,
               state_o
    );

endinterface

// File: rtl/pc_bp_match.sv
// -----------------------------------------------------------------------------
// pc_bp_match
// NUM_BP address breakpoint comparators with a lowest-index priority encoder.
// Only the word index (pc[PC_W-1:2]) is compared.
//   pc_i      : current PC (byte address)
//   bp_en_i   : per-breakpoint enable
//   bp_addr_i : packed breakpoint byte addresses, bp k at [k*PC_W +: PC_W]
//   hit_o     : any enabled breakpoint matches
//   idx_o     : lowest matching breakpoint index (0 when no match)
// -----------------------------------------------------------------------------
module pc_bp_match #(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 4
) (
    input  logic [PC_W-1:0]        pc_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
    output logic                   hit_o,
    output logic [2:0]             idx_o
);

    logic [NUM_BP-1:0] match;

    for (genvar k = 0; k < NUM_BP; k++) begin : g_cmp
        assign match[k] = bp_en_i[k] &&
                          (pc_i[PC_W-1:2] == bp_addr_i[k*PC_W+2 +: PC_W-2]);
    end

    // Walk from the top down so the lowest matching index is written last.
    always_comb begin
        hit_o = |match;
        idx_o = 3'd0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (match[k]) begin
                idx_o = 3'(k);
            end
        end
    end

endmodule

// File: rtl/pc_run_ctrl.sv
// -----------------------------------------------------------------------------
// pc_run_ctrl
// Run control for the core PC. Gates PC advance (run_o) in three modes:
// FREE (run to end address), STEP (one instruction) and COUNT (N
// instructions), with NUM_BP address breakpoints, a halt-cause register and a
// retired-instruction counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_run_ctrl_if.slave -- debug controls in; run_o, pc_clr_o,
//                busy_o, halt_cause_o, bp_idx_o, retired_o, state_o out
// -----------------------------------------------------------------------------
module pc_run_ctrl
    import pc_run_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_run_ctrl_if.slave  bus
);

    run_state_t        state;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  remaining;
    logic              skip_bp;
    logic [2:0]        cause_q;
    logic [2:0]        idx_q;
    logic [CNT_W-1:0]  retired_q;
    logic              pc_clr_q;

    logic              bp_raw;
    logic [2:0]        bp_raw_idx;

    logic              in_run;
    logic              cnt_mode;
    logic              end_hit;
    logic              bp_hit;
    logic              cnt_hit;
    logic              stop_hit;
    logic              any_hit;
    logic              run_en;
    logic [2:0]        cause_nxt;

    pc_bp_match #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .pc_i      (bus.pc_i),
        .bp_en_i   (bus.bp_en_i),
        .bp_addr_i (bus.bp_addr_i),
        .hit_o     (bp_raw),
        .idx_o     (bp_raw_idx)
    );

    // Hit terms are evaluated on the live PC so run_o drops in the very
    // cycle the PC reaches a halt address; the PC never overshoots.
    always_comb begin
        in_run   = (state == ST_RUN);
        cnt_mode = (mode_q == MODE_STEP) || (mode_q == MODE_COUNT);
        end_hit  = in_run && (bus.pc_i[PC_W-1:2] == bus.end_addr_i);
        // skip_bp lets a resume execute the breakpoint instruction once.
        bp_hit   = in_run && bp_raw && !skip_bp;
        cnt_hit  = in_run && cnt_mode && (remaining == '0);
        stop_hit = in_run && bus.stop_i;
        any_hit  = stop_hit || end_hit || bp_hit || cnt_hit;
        run_en   = in_run && !any_hit && !bus.clr_i;
    end

    // Halt-cause priority: STOP > END > BREAK > COUNT/STEP.
    always_comb begin
        cause_nxt = CAUSE_NONE;
        if (stop_hit) begin
            cause_nxt = CAUSE_STOP;
        end else if (end_hit) begin
            cause_nxt = CAUSE_END;
        end else if (bp_hit) begin
            cause_nxt = CAUSE_BREAK;
        end else if (cnt_hit) begin
            cause_nxt = (mode_q == MODE_STEP) ? CAUSE_STEP : CAUSE_COUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_FREE;
            remaining <= '0;
            skip_bp   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            idx_q     <= 3'd0;
            retired_q <= '0;
            pc_clr_q  <= 1'b0;
        end else if (bus.clr_i) begin
            state     <= ST_IDLE;
            remaining <= '0;
            skip_bp   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            idx_q     <= 3'd0;
            retired_q <= '0;
            pc_clr_q  <= 1'b1;
        end else begin
            pc_clr_q <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (bus.start_i) begin
                        state   <= ST_RUN;
                        mode_q  <= norm_mode(bus.mode_i);
                        skip_bp <= 1'b1;
                        cause_q <= CAUSE_NONE;
                        case (norm_mode(bus.mode_i))
                            MODE_COUNT: remaining <= bus.step_cnt_i;
                            MODE_STEP:  remaining <= CNT_W'(1);
                            default:    remaining <= '0;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (any_hit) begin
                        state   <= ST_HALT;
                        cause_q <= cause_nxt;
                        if (cause_nxt == CAUSE_BREAK) begin
                            idx_q <= bp_raw_idx;
                        end
                    end else if (run_en) begin
                        retired_q <= retired_q + CNT_W'(1);
                        skip_bp   <= 1'b0;
                        if (cnt_mode) begin
                            remaining <= remaining - CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.run_o        = run_en;
    assign bus.pc_clr_o     = pc_clr_q;
    assign bus.busy_o       = in_run;
    assign bus.halt_cause_o = cause_q;
    assign bus.bp_idx_o     = idx_q;
    assign bus.retired_o    = retired_q;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_run_ctrl
// Bench for pc_run_ctrl. A small core model advances pc by 4 on every cycle
// with run_o high and clears it on pc_clr_o. Each run pushes its expected
// halt record (cause, pc, retired, run cycles, bp index) onto exp_q when the
// start is driven; the record is popped and compared once the controller
// leaves RUN.
// -----------------------------------------------------------------------------
module tb_pc_run_ctrl;
    import pc_run_pkg::*;

    localparam int PC_W   = 32;
    localparam int NUM_BP = 4;
    localparam int CNT_W  = 32;
    localparam int W      = 32;
    localparam logic [31:0] NO_STOP = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_run_ctrl_if #(.PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) bus ();

    pc_run_ctrl #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- core model ----------------
    logic [31:0] pc          = '0;
    logic        pc_load     = 1'b0;
    logic [31:0] pc_load_val = '0;
    logic [31:0] run_cnt     = '0;

    assign bus.pc_i = pc;

    always @(posedge clk) begin
        if (pc_load)           pc <= pc_load_val;
        else if (bus.pc_clr_o) pc <= '0;
        else if (bus.run_o)    pc <= pc + 32'd4;
        if (bus.run_o) run_cnt <= run_cnt + 32'd1;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_pc(input logic [31:0] v);
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = v;
        @(negedge clk);
        pc_load     = 1'b0;
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        bus.clr_i = 1'b1;
        @(negedge clk);
        bus.clr_i = 1'b0;
        check({tag, ".pc_clr"},  32'(bus.pc_clr_o), 32'd1);
        check({tag, ".cause"},   32'(bus.halt_cause_o), 32'(CAUSE_NONE));
        check({tag, ".retired"}, bus.retired_o, 32'd0);
        check({tag, ".state"},   32'(bus.state_o), 32'(ST_IDLE));
        @(negedge clk);
        check({tag, ".pc_clr_1cyc"}, 32'(bus.pc_clr_o), 32'd0);
    endtask

    // Start a run, optionally raise stop_i when pc reaches stop_pc, wait for
    // the halt and compare the popped record.
    task automatic do_run(input string tag, input logic [1:0] mode,
                          input logic [31:0] cnt, input logic [31:0] stop_pc,
                          input logic [31:0] e_cause, input logic [31:0] e_pc,
                          input logic [31:0] e_ret, input logic [31:0] e_runs,
                          input logic [31:0] e_idx);
        logic [31:0] runs0;
        int n;
        exp_q.push_back(e_cause);
        exp_q.push_back(e_pc);
        exp_q.push_back(e_ret);
        exp_q.push_back(e_runs);
        exp_q.push_back(e_idx);
        @(negedge clk);
        runs0          = run_cnt;
        bus.start_i    = 1'b1;
        bus.mode_i     = mode;
        bus.step_cnt_i = cnt;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0;
        while (bus.busy_o && n < 1000) begin
            bus.stop_i = (pc == stop_pc);
            @(negedge clk);
            n++;
        end
        bus.stop_i = 1'b0;
        check({tag, ".in_time"}, 32'(n < 1000), 32'd1);
        check({tag, ".cause"},   32'(bus.halt_cause_o), exp_q.pop_front());
        check({tag, ".pc"},      pc, exp_q.pop_front());
        check({tag, ".retired"}, bus.retired_o, exp_q.pop_front());
        check({tag, ".runs"},    run_cnt - runs0, exp_q.pop_front());
        check({tag, ".bp_idx"},  32'(bus.bp_idx_o), exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.clr_i      = 1'b0;
        bus.mode_i     = MODE_FREE;
        bus.step_cnt_i = '0;
        bus.end_addr_i = 30'h73;
        bus.bp_en_i    = '0;
        bus.bp_addr_i  = {32'h0000_0100, 32'h0000_0200, 32'h0000_0040, 32'h0000_0040};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.run",     32'(bus.run_o), 32'd0);
        check("rst.pc_clr",  32'(bus.pc_clr_o), 32'd0);
        check("rst.busy",    32'(bus.busy_o), 32'd0);
        check("rst.cause",   32'(bus.halt_cause_o), 32'(CAUSE_NONE));
        check("rst.bp_idx",  32'(bus.bp_idx_o), 32'd0);
        check("rst.retired", bus.retired_o, 32'd0);
        check("rst.state",   32'(bus.state_o), 32'(ST_IDLE));

        // FREE run from 0 to word 0x73
        do_run("free", MODE_FREE, 32'd0, NO_STOP, 32'(CAUSE_END), 32'h1CC, 32'd115, 32'd115, 32'd0);

        // STEP four times from 0x10
        do_clr("clr1");
        load_pc(32'h10);
        do_run("step1", MODE_STEP, 32'd0, NO_STOP, 32'(CAUSE_STEP), 32'h14, 32'd1, 32'd1, 32'd0);
        do_run("step2", MODE_STEP, 32'd0, NO_STOP, 32'(CAUSE_STEP), 32'h18, 32'd2, 32'd1, 32'd0);
        do_run("step3", MODE_STEP, 32'd0, NO_STOP, 32'(CAUSE_STEP), 32'h1C, 32'd3, 32'd1, 32'd0);
        do_run("step4", MODE_STEP, 32'd0, NO_STOP, 32'(CAUSE_STEP), 32'h20, 32'd4, 32'd1, 32'd0);

        // COUNT 5, then COUNT 0
        do_run("cnt5", MODE_COUNT, 32'd5, NO_STOP, 32'(CAUSE_COUNT), 32'h34, 32'd9, 32'd5, 32'd0);
        do_run("cnt0", MODE_COUNT, 32'd0, NO_STOP, 32'(CAUSE_COUNT), 32'h34, 32'd9, 32'd0, 32'd0);

        // Breakpoint: bp0 disabled, bp1 enabled, both at 0x40; then resume
        do_clr("clr2");
        bus.bp_en_i = 4'b0010;
        do_run("bp",     MODE_FREE, 32'd0, NO_STOP, 32'(CAUSE_BREAK), 32'h40,  32'd16,  32'd16, 32'd1);
        do_run("resume", MODE_FREE, 32'd0, NO_STOP, 32'(CAUSE_END),   32'h1CC, 32'd115, 32'd99, 32'd1);

        // stop_i and breakpoint in the same cycle
        do_clr("clr3");
        do_run("stop_bp", MODE_FREE, 32'd0, 32'h40, 32'(CAUSE_STOP), 32'h40, 32'd16, 32'd16, 32'd0);

        // stop_i while halted does nothing
        @(negedge clk);
        bus.stop_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
        check("stop_halt.cause", 32'(bus.halt_cause_o), 32'(CAUSE_STOP));
        check("stop_halt.state", 32'(bus.state_o), 32'(ST_HALT));

        // clr_i together with start_i
        @(negedge clk);
        bus.clr_i   = 1'b1;
        bus.start_i = 1'b1;
        bus.mode_i  = MODE_FREE;
        @(negedge clk);
        bus.clr_i   = 1'b0;
        bus.start_i = 1'b0;
        check("clr_start.state",   32'(bus.state_o), 32'(ST_IDLE));
        check("clr_start.pc_clr",  32'(bus.pc_clr_o), 32'd1);
        check("clr_start.cause",   32'(bus.halt_cause_o), 32'(CAUSE_NONE));
        check("clr_start.retired", bus.retired_o, 32'd0);
        @(negedge clk);
        check("clr_start.pc_clr_1cyc", 32'(bus.pc_clr_o), 32'd0);
        check("clr_start.pc",          pc, 32'd0);

        // Asynchronous reset mid-run
        bus.bp_en_i = '0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = MODE_FREE;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("mid.run",     32'(bus.run_o), 32'd1);
        check("mid.retired", bus.retired_o, 32'd10);
        rst_n = 1'b0;
        #1;
        check("arst.run",     32'(bus.run_o), 32'd0);
        check("arst.busy",    32'(bus.busy_o), 32'd0);
        check("arst.cause",   32'(bus.halt_cause_o), 32'(CAUSE_NONE));
        check("arst.bp_idx",  32'(bus.bp_idx_o), 32'd0);
        check("arst.retired", bus.retired_o, 32'd0);
        check("arst.pc_clr",  32'(bus.pc_clr_o), 32'd0);
        check("arst.state",   32'(bus.state_o), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        check("arst.pc_hold", pc, 32'h28);
        rst_n = 1'b1;
        do_run("after_rst", MODE_FREE, 32'd0, NO_STOP, 32'(CAUSE_END), 32'h1CC, 32'd105, 32'd105, 32'd0);

        check("sb.empty", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
